// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the 8x8 shift-add multiplier.
package mult_pkg;
  localparam int OP_W  = 8;
  localparam int ITERS = 8;
  localparam int CNT_W = $clog2(ITERS);
  localparam int ACC_W = 2 * OP_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;
endpackage

// File: rtl/mult_datapath.sv
// Operand register, 17-bit {carry,acc} accumulator, adder and product register.
module mult_datapath
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              capture_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [2*OP_W-1:0] product_o
);
  logic [OP_W-1:0]   operand_q, operand_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [2*OP_W-1:0] product_q, product_d;
  logic [OP_W:0]     sum;

  always_comb begin
    operand_d = operand_q;
    acc_d     = acc_q;
    product_d = product_q;
    sum       = {1'b0, acc_q[2*OP_W-1:OP_W]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    if (load_i) begin
      operand_d = a_i;
      acc_d     = {1'b0, {OP_W{1'b0}}, b_i};
    end else if (step_i) begin
      // Add into the upper half, then shift the whole 17-bit word right.
      acc_d = {1'b0, sum, acc_q[OP_W-1:1]};
    end
    // Capture shares the edge of the final step, so take the post-step value.
    if (capture_i) product_d = acc_d[2*OP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_q <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      operand_q <= operand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;
endmodule

// File: rtl/mult_unit.sv
// Sequential 8x8 unsigned multiplier: IDLE -> CALC (8 steps) -> DONE -> IDLE.
module mult_unit
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   multiplicand,
  input  logic [OP_W-1:0]   multiplier,
  output logic [2*OP_W-1:0] product,
  output logic              valid,
  output logic              busy
);
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q, busy_q;
  logic             load, step, capture;

  assign load    = (state_q == IDLE) && start;
  assign step    = (state_q == CALC);
  assign capture = step && (cnt_q == CNT_W'(ITERS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= CALC;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (capture) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  mult_datapath u_dp (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (load),
    .step_i    (step),
    .capture_i (capture),
    .a_i       (multiplicand),
    .b_i       (multiplier),
    .product_o (product)
  );

  assign valid = valid_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench: timing-window reference model plus directed and random operands.
module tb_mult_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] product;
  logic        valid, busy;

  int tests = 0;
  int fails = 0;

  mult_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .product      (product),
    .valid        (valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an accepted request at edge n yields A*B and valid after edge n+8,
  // and the unit stays busy through edge n+8.
  int          n = 0;
  int          acc_edge = -100;
  logic [15:0] m_pend = '0, m_prod = '0;
  logic        m_busy = 1'b0, m_valid = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_edge <= -100;
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_prod   <= '0;
    end else begin
      n <= n + 1;
      if (!m_busy && start) begin
        acc_edge <= n;
        m_pend   <= 16'(a) * 16'(b);
        m_busy   <= 1'b1;
        m_valid  <= 1'b0;
      end else begin
        m_busy  <= (n - acc_edge >= 0) && (n - acc_edge <= 8);
        m_valid <= (n - acc_edge == 8);
        if (n - acc_edge == 8) m_prod <= m_pend;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
    chk("cyc_valid", {31'b0, valid}, {31'b0, m_valid});
    chk("cyc_product", {16'b0, product}, {16'b0, m_prod});
  end

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input string nm);
    int vcnt = 0;
    int vat = -1;
    logic [15:0] pr = 16'hxxxx;
    logic [15:0] mp = 16'hxxxx;
    wait_idle();
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (valid) begin
        vcnt++;
        if (vat < 0) begin vat = k; pr = product; mp = m_prod; end
      end
    end
    chk({nm, "_product"}, {16'b0, pr}, {16'b0, exp});
    chk({nm, "_model"}, {16'b0, mp}, {16'b0, exp});
    chk({nm, "_valid_count"}, vcnt, 1);
    chk({nm, "_latency"}, vat, 8);
  endtask

  initial begin
    int vcnt, vat, last, cnt, ops, cyc;
    logic [15:0] pr;

    start = 1'b1; a = 8'd3; b = 8'd4;
    repeat (3) @(negedge clk);
    chk("rst_product", {16'b0, product}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    run_op(8'd13, 8'd11, 16'h008F, "a13_b11");
    run_op(8'd255, 8'd255, 16'hFE01, "a255_b255");
    run_op(8'd0, 8'd200, 16'h0000, "a0_b200");
    run_op(8'd200, 8'd0, 16'h0000, "a200_b0");
    run_op(8'd1, 8'd1, 16'h0001, "a1_b1");

    // Start pulse during CALC must not disturb the running operation.
    wait_idle();
    a = 8'd13; b = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vcnt = 0; vat = -1; pr = 16'hxxxx;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) begin start = 1'b1; a = 8'd99; b = 8'd77; end
      if (k == 4) start = 1'b0;
      if (k <= 8) chk("ign_busy", {31'b0, busy}, 32'd1);
      if (valid) begin vcnt++; if (vat < 0) begin vat = k; pr = product; end end
    end
    chk("ign_product", {16'b0, pr}, 32'h008F);
    chk("ign_valid_count", vcnt, 1);
    chk("ign_latency", vat, 8);

    // Reset mid-operation.
    wait_idle();
    a = 8'd50; b = 8'd60; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_product", {16'b0, product}, 32'd0);
    chk("abort_valid", {31'b0, valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("abort_no_valid", vcnt, 0);
    run_op(8'd7, 8'd9, 16'h003F, "a7_b9");

    // Start held high: back-to-back operations every 10 cycles.
    wait_idle();
    a = 8'd21; b = 8'd3; start = 1'b1;
    last = -1; cnt = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (valid) begin
        if (last >= 0) chk("b2b_gap", k - last, 10);
        chk("b2b_product", {16'b0, product}, 32'd63);
        last = k;
        cnt++;
      end
    end
    start = 1'b0;
    chk("b2b_count", cnt, 4);
    wait_idle();

    // Random regression; the per-cycle compare checks each product against A*B.
    ops = 0; cyc = 0;
    while (ops < 1000 && cyc < 20000) begin
      start = ($urandom_range(0, 9) < 8);
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
      if ($urandom_range(0, 15) == 0) b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
      @(negedge clk);
      cyc++;
      if (valid) ops++;
    end
    chk("rand_ops_done", {31'b0, (ops >= 1000)}, 32'd1);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL provide clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-002 SHALL provide reset, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL provide start, input, 1 bit, request strobe, sampled on the rising edge of clk.
REQ-004 SHALL provide multiplicand, input, 8 bits, unsigned operand A.
REQ-005 SHALL provide multiplier, input, 8 bits, unsigned operand B.
REQ-006 SHALL provide product, output, 16 bits, unsigned A*B, registered.
REQ-007 SHALL provide valid, output, 1 bit, single-cycle pulse marking product as newly complete.
REQ-008 SHALL provide busy, output, 1 bit, high while an operation is in progress (state not IDLE).

Function
REQ-009 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-010 SHALL, in IDLE with start=1 at a clock edge, on that edge: latch multiplicand into an 8-bit operand register; load {carry=0, acc[15:8]=0, acc[7:0]=multiplier}; clear the iteration counter; enter CALC.
REQ-011 SHALL, in each CALC cycle, apply one shift-add step: if acc[0]=1 then {carry,acc[15:8]} = acc[15:8] + operand (9-bit result), else {carry,acc[15:8]} = {0,acc[15:8]}; then shift the 17-bit {carry,acc} right by one into acc; increment the counter.
REQ-012 SHALL leave CALC for DONE on the edge that completes the 8th step (counter 7 -> wrap); the counter SHALL be 3 bits wide and wrap to 0.
REQ-013 SHALL copy acc to product on the edge that enters DONE, and assert valid only during the DONE cycle.
REQ-014 SHALL, in DONE, return to IDLE unconditionally on the next edge, deasserting valid.
REQ-015 SHALL produce valid exactly 8 clock cycles after the edge on which start was accepted, and accept a new start no earlier than 10 edges after the previous accepted start.
REQ-016 SHALL ignore start while in CALC or DONE; the operation in progress SHALL be unaffected.
REQ-017 SHALL hold product stable from DONE until the next completed operation; operand inputs SHALL be don't-care outside the accept edge.
REQ-018 SHALL give a result exact for all 2^16 operand pairs; no overflow is possible (max 0xFE01).

Reset
REQ-019 SHALL, while reset=0, force state=IDLE, counter=0, operand=0, acc=0, carry=0, product=0x0000, valid=0, busy=0, independent of clk.
REQ-020 SHALL abort any in-progress operation on reset assertion, with no valid pulse emitted for that operation.
REQ-021 SHALL ignore start on the first edge after reset release only if reset is still low at that edge; otherwise start SHALL be accepted normally.

Structure
REQ-022 SHALL place the state encodings (IDLE=2'b00, CALC=2'b01, DONE=2'b10), operand width (8) and iteration count (8) in the shared package mult_pkg.
REQ-023 SHALL split the design into the FSM/counter in mult_unit and one sub-module, mult_datapath, holding the operand register, the 17-bit accumulator and the adder.
REQ-024 SHALL drive mult_datapath with the control signals load, step and capture only.

Verification
REQ-025 SHALL verify that start with A=13, B=11 gives product=0x008F, with valid high for exactly one cycle, 8 cycles after acceptance.
REQ-026 SHALL verify that A=255, B=255 gives product=0xFE01, and that A=0, B=200 and A=200, B=0 each give 0x0000.
REQ-027 SHALL verify that a start pulse at cycle 3 of CALC, with other operands, is ignored: the original product is returned, busy stays high and no second valid pulse occurs.
REQ-028 SHALL verify that reset asserted at CALC step 4 gives product=0, valid=0 and busy=0 immediately, with no valid pulse afterwards; a fresh start with A=7, B=9 then gives 0x003F.
REQ-029 SHALL verify that start held high continuously produces back-to-back operations, with valid pulses spaced 10 cycles apart.
REQ-030 SHALL run a random regression of at least 1000 operand pairs, comparing each product against A*B.
